// File: rtl/part_2_cosim_pkg.sv
// rtl/part_2_cosim_pkg.sv - shared vector type, widths and priority helper for the SUT capture path
package part_2_cosim_pkg;
  localparam int CS_NUM_CLKS = 4;
  localparam int CS_VEC_W    = 9;
  localparam int CS_SEQ_W    = 8;
  localparam int CS_IDX_W    = $clog2(CS_NUM_CLKS);

  typedef struct packed {
    logic [CS_IDX_W-1:0] idx;
    logic [CS_SEQ_W-1:0] seq;
    logic [CS_VEC_W-1:0] data;
  } sut_vec_t;

  localparam int CS_ENTRY_W = $bits(sut_vec_t);

  // Index of the lowest set bit; 0 when nothing is set, so callers qualify with |v.
  function automatic logic [CS_IDX_W-1:0] lowest_idx(input logic [CS_NUM_CLKS-1:0] v);
    lowest_idx = '0;
    for (int i = CS_NUM_CLKS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CS_IDX_W'(i);
    end
  endfunction
endpackage

// File: rtl/part_2_vec_fifo.sv
// rtl/part_2_vec_fifo.sv - synchronous FIFO of tagged capture vectors
module part_2_vec_fifo
  import part_2_cosim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic [CS_ENTRY_W-1:0]   push_data,
  input  logic                    pop,
  output logic [CS_ENTRY_W-1:0]   head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sut_vec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/part_2_sut_capture.sv
// rtl/part_2_sut_capture.sv - mission-clock edge capture, per-clock snapshot, arbiter and freeze control
module part_2_sut_capture
  import part_2_cosim_pkg::*;
#(
  parameter int                  NUM_CLKS      = CS_NUM_CLKS,
  parameter int                  DATA_W        = CS_VEC_W,
  parameter int                  DEPTH         = 4,
  parameter logic [NUM_CLKS-1:0] DATA_CLK_MASK = 4'b1000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CLKS-1:0]         mclk_h,
  input  logic [NUM_CLKS-1:0]         cap_en,
  input  logic                        sut_valid,
  input  logic [DATA_W-2:0]           sut_data,
  output logic                        vec_valid,
  input  logic                        vec_ready,
  output logic [$clog2(NUM_CLKS)-1:0] vec_clk_idx,
  output logic [7:0]                  vec_seq,
  output logic [DATA_W-1:0]           vec_data,
  output logic [NUM_CLKS-1:0]         freeze_req,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int IDX_W = $clog2(NUM_CLKS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_CLKS-1:0] mclk_d;
  logic [NUM_CLKS-1:0] cap_edge;
  logic [NUM_CLKS-1:0] pend;
  logic [NUM_CLKS-1:0] pend_nxt;
  logic [NUM_CLKS-1:0] push_oh;
  logic [NUM_CLKS-1:0] drop;
  logic [NUM_CLKS-1:0] freeze_nxt;
  logic [DATA_W-1:0]   snap            [NUM_CLKS];
  logic [CNT_W-1:0]    outstanding     [NUM_CLKS];
  logic [CNT_W-1:0]    outstanding_nxt [NUM_CLKS];
  logic [CS_SEQ_W-1:0] seq;
  logic [IDX_W-1:0]    push_idx;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CS_ENTRY_W-1:0] head_bits;
  sut_vec_t            push_vec;
  sut_vec_t            head_vec;

  assign cap_edge  = mclk_h & ~mclk_d & cap_en;
  assign vec_valid = ~fifo_empty;
  assign pop       = vec_valid & vec_ready;
  assign push      = (|pend) & (~fifo_full | pop);
  assign push_idx  = lowest_idx(pend);
  assign head_vec  = head_bits;

  assign vec_clk_idx = head_vec.idx;
  assign vec_seq     = head_vec.seq;
  assign vec_data    = head_vec.data;

  always_comb begin
    push_oh = '0;
    if (push) push_oh[push_idx] = 1'b1;
    push_vec.idx  = push_idx;
    push_vec.seq  = seq;
    push_vec.data = snap[push_idx];
    // An edge coinciding with its own clock's push re-arms pend instead of overflowing.
    drop     = cap_edge & pend & ~push_oh;
    pend_nxt = (pend & ~push_oh) | cap_edge;
    for (int i = 0; i < NUM_CLKS; i++) begin
      outstanding_nxt[i] = outstanding[i] + CNT_W'(push_oh[i])
                         - CNT_W'(pop && (head_vec.idx == IDX_W'(i)));
      freeze_nxt[i] = pend_nxt[i] | (outstanding_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    mclk_d <= mclk_h;
    if (rst_i) begin
      pend       <= '0;
      seq        <= '0;
      freeze_req <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_CLKS; i++) outstanding[i] <= '0;
    end else begin
      pend       <= pend_nxt;
      freeze_req <= freeze_nxt;
      if (push) seq <= seq + CS_SEQ_W'(1);
      if (|drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      for (int i = 0; i < NUM_CLKS; i++) begin
        outstanding[i] <= outstanding_nxt[i];
        if (cap_edge[i] && !drop[i])
          snap[i] <= DATA_CLK_MASK[i] ? {sut_valid, sut_data} : '0;
      end
    end
  end

  part_2_vec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (push_vec),
    .pop       (pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );
endmodule

// File: tb/tb_part_2_sut_capture.sv
// tb/tb_part_2_sut_capture.sv - self-checking bench for part_2_sut_capture with a queue-based reference model
module tb_part_2_sut_capture;
  localparam int NC    = 4;
  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] mclk_h;
  logic [3:0] cap_en;
  logic       sut_valid;
  logic [7:0] sut_data;
  logic       vec_valid;
  logic       vec_ready;
  logic [1:0] vec_clk_idx;
  logic [7:0] vec_seq;
  logic [8:0] vec_data;
  logic [3:0] freeze_req;
  logic [2:0] fill_level;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  part_2_sut_capture dut (
    .clk_i(clk_i), .rst_i(rst_i), .mclk_h(mclk_h), .cap_en(cap_en),
    .sut_valid(sut_valid), .sut_data(sut_data), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_clk_idx(vec_clk_idx), .vec_seq(vec_seq),
    .vec_data(vec_data), .freeze_req(freeze_req), .fill_level(fill_level),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending captures per clock and an ordered queue of delivered vectors.
  typedef struct { int idx; int seq; int data; } ent_t;
  ent_t       q[$];
  bit         pend_m[NC];
  int         snap_m[NC];
  int         seq_m;
  bit         ovf_m;
  logic [3:0] prev_m;
  logic [3:0] data_mask = 4'b1000;
  int         got_seq[$];

  task automatic model_step();
    int   pidx;
    bit   pop_m;
    bit   push_m;
    ent_t e;
    if (rst_i) begin
      q.delete();
      for (int i = 0; i < NC; i++) pend_m[i] = 0;
      seq_m  = 0;
      ovf_m  = 0;
      prev_m = mclk_h;
      return;
    end
    pop_m = (q.size() != 0) && vec_ready;
    pidx  = -1;
    for (int i = NC - 1; i >= 0; i--) if (pend_m[i]) pidx = i;
    push_m = (pidx >= 0) && ((q.size() < DEPTH) || pop_m);
    if (pop_m) void'(q.pop_front());
    if (push_m) begin
      e.idx = pidx; e.seq = seq_m; e.data = snap_m[pidx];
      q.push_back(e);
      pend_m[pidx] = 0;
      seq_m = (seq_m + 1) % 256;
    end
    if (clr_ovf) ovf_m = 0;
    for (int i = 0; i < NC; i++) begin
      if (mclk_h[i] && !prev_m[i] && cap_en[i]) begin
        if (pend_m[i]) ovf_m = 1;
        else begin
          pend_m[i] = 1;
          snap_m[i] = data_mask[i] ? int'({sut_valid, sut_data}) : 0;
        end
      end
    end
    prev_m = mclk_h;
  endtask

  function automatic logic [3:0] freeze_m();
    logic [3:0] f;
    for (int i = 0; i < NC; i++) f[i] = pend_m[i];
    foreach (q[k]) f[q[k].idx] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic tick_rec();
    if (vec_valid && vec_ready) got_seq.push_back(int'(vec_seq));
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; mclk_h = '0; vec_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mclk_h = 4'b1000; cap_en = 4'hF; vec_ready = 1'b1;
    clr_ovf = 1'b0; sut_valid = 1'b0; sut_data = '0;
    tick(); tick();
    n_checks++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vec_valid got %0b want 0", vec_valid); end
    n_checks++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    n_checks++; if (freeze_req !== 4'b0) begin n_fail++; $display("FAIL reset_freeze got %b want 0000", freeze_req); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    rst_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if (vec_valid !== 1'b0 || freeze_req !== 4'b0) begin
        n_fail++; $display("FAIL held_high_no_edge cycle %0d got valid=%0b freeze=%b want 0/0000", c, vec_valid, freeze_req);
      end
    end
    mclk_h = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    vec_ready = 1'b1; sut_valid = 1'b1; sut_data = 8'hA5;
    mclk_h = 4'b1000;
    tick();
    n_checks++; if (freeze_req !== 4'b1000 || vec_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_t1 got freeze=%b valid=%0b want 1000/0", freeze_req, vec_valid);
    end
    sut_data = 8'h00;
    tick();
    n_checks++; if ({vec_valid, vec_clk_idx, vec_seq, vec_data} !== {1'b1, 2'd3, 8'd0, 9'h1A5}) begin
      n_fail++; $display("FAIL single_head got v=%0b idx=%0d seq=%0d data=%h want 1/3/0/1a5", vec_valid, vec_clk_idx, vec_seq, vec_data);
    end
    n_checks++; if (freeze_req !== 4'b1000) begin n_fail++; $display("FAIL single_freeze_t2 got %b want 1000", freeze_req); end
    tick();
    n_checks++; if (vec_valid !== 1'b0 || freeze_req !== 4'b0) begin
      n_fail++; $display("FAIL single_after_pop got valid=%0b freeze=%b want 0/0000", vec_valid, freeze_req);
    end
    mclk_h = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    vec_ready = 1'b1; sut_valid = 1'b1; sut_data = 8'h3C;
    mclk_h = 4'b1001;
    tick();
    tick();
    n_checks++; if ({vec_valid, vec_clk_idx, vec_seq, vec_data} !== {1'b1, 2'd0, 8'd0, 9'h000}) begin
      n_fail++; $display("FAIL simul_first got v=%0b idx=%0d seq=%0d data=%h want 1/0/0/000", vec_valid, vec_clk_idx, vec_seq, vec_data);
    end
    n_checks++; if (freeze_req !== 4'b1001) begin n_fail++; $display("FAIL simul_freeze_a got %b want 1001", freeze_req); end
    tick();
    n_checks++; if ({vec_valid, vec_clk_idx, vec_seq, vec_data} !== {1'b1, 2'd3, 8'd1, 9'h13C}) begin
      n_fail++; $display("FAIL simul_second got v=%0b idx=%0d seq=%0d data=%h want 1/3/1/13c", vec_valid, vec_clk_idx, vec_seq, vec_data);
    end
    n_checks++; if (freeze_req !== 4'b1000) begin n_fail++; $display("FAIL simul_freeze_b got %b want 1000", freeze_req); end
    tick();
    n_checks++; if (vec_valid !== 1'b0 || freeze_req !== 4'b0) begin
      n_fail++; $display("FAIL simul_drained got valid=%0b freeze=%b want 0/0000", vec_valid, freeze_req);
    end
    mclk_h = '0;
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    vec_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mclk_h = 4'b0001; tick();
      mclk_h = 4'b0000; tick();
    end
    n_checks++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill got %0d want 4", fill_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_checks++; if (freeze_req !== 4'b0001) begin n_fail++; $display("FAIL ovf_freeze got %b want 0001", freeze_req); end
    got_seq.delete();
    vec_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick_rec();
    n_checks++; if (got_seq.size() != 5) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 5", got_seq.size()); end
    foreach (got_seq[k]) begin
      n_checks++; if (got_seq[k] != k) begin n_fail++; $display("FAIL ovf_drain_seq[%0d] got %0d want %0d", k, got_seq[k], k); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b want 0", overflow); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    vec_ready = 1'b1;
    got_seq.delete();
    for (int k = 0; k < 257; k++) begin
      sut_data = 8'($urandom);
      mclk_h = 4'b1000; tick_rec();
      mclk_h = 4'b0000; tick_rec();
    end
    for (int c = 0; c < 6; c++) tick_rec();
    n_checks++; if (got_seq.size() != 257) begin n_fail++; $display("FAIL wrap_count got %0d want 257", got_seq.size()); end
    foreach (got_seq[k]) begin
      n_checks++; if (got_seq[k] != k % 256) begin n_fail++; $display("FAIL wrap_seq[%0d] got %0d want %0d", k, got_seq[k], k % 256); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vec_ready = 1'b0;
    mclk_h = 4'b1001; tick();
    mclk_h = 4'b0000; tick();
    mclk_h = 4'b0001; tick();
    mclk_h = 4'b0000; tick(); tick(); tick();
    n_checks++; if (fill_level !== 3'd3 || freeze_req !== 4'b1001) begin
      n_fail++; $display("FAIL mid_setup got fill=%0d freeze=%b want 3/1001", fill_level, freeze_req);
    end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_checks++; if (vec_valid !== 1'b0 || fill_level !== 3'd0 || freeze_req !== 4'b0) begin
      n_fail++; $display("FAIL mid_reset got valid=%0b fill=%0d freeze=%b want 0/0/0000", vec_valid, fill_level, freeze_req);
    end
    vec_ready = 1'b1; sut_data = 8'h11; sut_valid = 1'b0;
    mclk_h = 4'b1000; tick(); tick();
    n_checks++; if ({vec_valid, vec_clk_idx, vec_seq, vec_data} !== {1'b1, 2'd3, 8'd0, 9'h011}) begin
      n_fail++; $display("FAIL mid_restart got v=%0b idx=%0d seq=%0d data=%h want 1/3/0/011", vec_valid, vec_clk_idx, vec_seq, vec_data);
    end
    mclk_h = '0; tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_i     = ($urandom_range(0, 299) == 0);
      mclk_h    = 4'($urandom);
      cap_en    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      vec_ready = ($urandom_range(0, 2) != 0);
      sut_valid = 1'($urandom);
      sut_data  = 8'($urandom);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++; if (vec_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, vec_valid, q.size() != 0); end
      n_checks++; if (fill_level !== 3'(q.size())) begin n_fail++; $display("FAIL rand_fill cyc %0d got %0d want %0d", c, fill_level, q.size()); end
      n_checks++; if (freeze_req !== freeze_m()) begin n_fail++; $display("FAIL rand_freeze cyc %0d got %b want %b", c, freeze_req, freeze_m()); end
      n_checks++; if (overflow !== ovf_m) begin n_fail++; $display("FAIL rand_overflow cyc %0d got %0b want %0b", c, overflow, ovf_m); end
      if (q.size() != 0) begin
        n_checks++; if ({vec_clk_idx, vec_seq, vec_data} !== {2'(q[0].idx), 8'(q[0].seq), 9'(q[0].data)}) begin
          n_fail++; $display("FAIL rand_head cyc %0d got idx=%0d seq=%0d data=%h want %0d/%0d/%h",
                             c, vec_clk_idx, vec_seq, vec_data, q[0].idx, q[0].seq, q[0].data);
        end
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_seq_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/part_2_sut_capture.md
Name: part_2_sut_capture

Overview:
Target-side capture stage sitting directly upstream of the target put path. It detects rising edges of the mission clocks in the utility-clock (clk_i) domain and snapshots the SUT output {valid, o_data} for each edge. Each snapshot becomes one tagged vector in a small FIFO, presented to the sender FSM over a valid/ready handshake. It requests a mission-clock freeze until that clock's vector has been handed off, which enforces lockstep with the initiator.

Parameters:
NUM_CLKS, 4, number of mission clocks tracked
DATA_W, 9, vector payload width ({valid, o_data})
DEPTH, 4, FIFO entries; power of 2, at least 2
DATA_CLK_MASK, 4'b1000, bit i=1: clock i carries SUT data; bit i=0: clock i sends an all-zero confirmation vector

Ports:
clk_i  in  1  utility clock
rst_i  in  1  synchronous active-high reset
mclk_h  in  NUM_CLKS  mission clocks, sampled as data on clk_i
cap_en  in  NUM_CLKS  per-clock capture enable
sut_valid  in  1  SUT valid output
sut_data  in  DATA_W-1  SUT data output (o_data)
vec_valid  out  1  FIFO head valid
vec_ready  in  1  sender accepts head
vec_clk_idx  out  $clog2(NUM_CLKS)  mission-clock index of head
vec_seq  out  8  sequence number of head
vec_data  out  DATA_W  payload of head
freeze_req  out  NUM_CLKS  freeze request per mission clock
fill_level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a capture was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - Outputs: vec_valid=0, freeze_req=0, fill_level=0, overflow=0.
  - Internal: seq=0, pend=0, FIFO emptied.
  - mclk_d loads the current mclk_h, so a clock that is high at reset release produces no edge.
  - A reset in mid-operation discards all queued vectors.
- Edge detect: edge[i] = mclk_h[i] & ~mclk_d[i] & cap_en[i]; mclk_d <= mclk_h every cycle.
- Edge seen in cycle T:
  - If pend[i]=0: snap[i] <= DATA_CLK_MASK[i] ? {sut_valid, sut_data} : 0, and pend[i] <= 1, visible in T+1.
  - If pend[i]=1 already: the new capture is dropped, overflow <= 1, and snap[i] is unchanged.
- Arbiter:
  - Each cycle, push at most one pending clock, lowest index first, if the FIFO is not full or a pop occurs in the same cycle.
  - Entry = {idx, seq, snap[idx]}. On push, pend[idx] is cleared and seq increments mod 256 (255 to 0).
  - An edge on the same clock in the same cycle as its push sets pend again with a fresh snapshot; it is not an overflow.
- Latency: edge sampled in T gives pend set in T+1, push in T+1, vec_valid=1 in T+2 when the FIFO was empty.
- Handshake:
  - A pop occurs when vec_valid & vec_ready.
  - Head outputs are stable while vec_valid=1 and vec_ready=0.
  - vec_valid never drops without a pop, except on reset.
- FIFO boundaries:
  - Full with no pop: no push; pend bits are held.
  - Full with pop: push and pop in the same cycle; fill_level unchanged.
  - Empty: vec_valid=0 and head outputs don't-care; a push into an empty FIFO is not bypassed (latency 1 to vec_valid).
  - Pointers wrap modulo DEPTH.
- freeze_req[i] (registered) = pend[i] | (outstanding[i] != 0):
  - outstanding[i] counts FIFO entries for clock i; it increments on push and decrements on pop.
  - freeze_req asserts in T+1 after an edge in T.
  - freeze_req deasserts the cycle after the pop of the last entry for that clock, provided pend is clear.
- overflow: set by a dropped capture, cleared by clr_ovf. Set wins if both happen in the same cycle.
- cap_en[i] falling: pending and queued vectors for clock i still drain normally.

Decomposition:
- Package part_2_cosim_pkg:
  - typedef sut_vec_t (idx, seq[7:0], data[DATA_W-1:0]).
  - Constants CS_NUM_CLKS=4, CS_VEC_W=9, CS_SEQ_W=8.
  - Function for lowest-set-bit priority select.
- Sub-module part_2_vec_fifo: synchronous FIFO of sut_vec_t with push/pop/full/empty/count and simultaneous push/pop at full.
- Edge detect, snapshots, arbiter and freeze logic stay in part_2_sut_capture.

Test Plan:
- Hold mclk_h[3]=1 through reset, then release and wait 10 cycles -> vec_valid stays 0, freeze_req=0.
- Single mclk_h[3] rising edge with sut={1,0xA5}, vec_ready=1 -> vec_valid in T+2 with idx=3, seq=0, data=0x1A5; freeze_req[3] high from T+1 until the cycle after the pop.
- Simultaneous edges on mclk_h[0] and mclk_h[3], vec_ready=1 -> first idx=0, data=0x000, seq=0; then idx=3, seq=1; both freeze bits clear after their pops.
- vec_ready=0 with six mclk_h[0] edges, freeze ignored -> fill_level=4, pend[0]=1, overflow=1 after the 6th edge; raising vec_ready drains 5 vectors with seq 0..4; clr_ovf clears overflow.
- 257 clk3 captures with vec_ready=1 -> seq runs 0..255, then 0.
- rst_i pulsed with 3 entries queued and freeze_req=4'b1001 -> next cycle vec_valid=0, fill_level=0, freeze_req=0, seq restarts at 0.
